// File: rtl/pixel_phase_responder.sv
// Responder for the pixel state controller: times exposure, drives the
// ADC ramp, steps the readout row select and returns completion flags.
module pixel_phase_responder #(
  parameter int unsigned EXPOSE_CYCLES = 255,
  parameter int unsigned RAMP_W        = 8,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned ROW_CYCLES    = 2
) (
  input  logic              clk,
  input  logic              state_reset_n,
  input  logic              frame_reset,
  input  logic              expose_enable,
  input  logic              convert,
  input  logic              ADC_reset,
  input  logic              read,
  output logic              expose_finished,
  output logic              ADC_finished,
  output logic [ROWS-1:0]   read_reg,
  output logic              read_done,
  output logic              erase,
  output logic              expose,
  output logic [RAMP_W-1:0] ramp_data
);

  localparam int unsigned RCW = $clog2(ROW_CYCLES + 1);
  localparam logic [15:0] EXP_LAST = 16'(EXPOSE_CYCLES - 1);
  localparam logic [RAMP_W-1:0] RAMP_TOP = '1;
  localparam logic [RAMP_W-1:0] RAMP_PRE = RAMP_TOP - RAMP_W'(1);
  localparam logic [RCW-1:0] ROW_LAST = RCW'(ROW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_EXP_DONE,
    S_CONVERT,
    S_CONV_DONE,
    S_READ,
    S_READ_DONE
  } state_t;

  state_t            r_state, w_nxt;
  logic [15:0]       r_exp_cnt, w_exp;
  logic [RAMP_W-1:0] r_ramp, w_ramp;
  logic [RCW-1:0]    r_row_cnt, w_row;
  logic [ROWS-1:0]   r_rsel, w_rsel;
  logic              r_expose, r_erase;
  logic              r_exp_fin, r_adc_fin, r_rd_done;

  always_comb begin
    w_nxt  = r_state;
    w_exp  = r_exp_cnt;
    w_ramp = r_ramp;
    w_row  = r_row_cnt;
    w_rsel = r_rsel;
    if (frame_reset) begin
      w_nxt  = S_ERASE;
      w_exp  = '0;
      w_ramp = '0;
      w_row  = '0;
      w_rsel = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_exp  = '0;
          w_ramp = '0;
          w_row  = '0;
          w_rsel = '0;
          if (expose_enable) begin
            w_nxt = S_EXPOSE;
          end else if (convert) begin
            w_nxt = S_CONVERT;
          end else if (read) begin
            w_nxt  = S_READ;
            w_rsel = ROWS'(1);
          end
        end
        S_ERASE: w_nxt = S_IDLE;
        S_EXPOSE: begin
          if (!expose_enable) begin
            w_nxt = S_IDLE;
            w_exp = '0;
          end else if (r_exp_cnt == EXP_LAST) begin
            w_nxt = S_EXP_DONE;
          end else begin
            w_exp = r_exp_cnt + 16'd1;
          end
        end
        S_EXP_DONE: begin
          if (!expose_enable) begin
            w_nxt = S_IDLE;
            w_exp = '0;
          end
        end
        S_CONVERT: begin
          if (!convert) begin
            w_nxt  = S_IDLE;
            w_ramp = '0;
          end else if (r_ramp == RAMP_PRE) begin
            w_nxt  = S_CONV_DONE;
            w_ramp = RAMP_TOP;
          end else begin
            w_ramp = r_ramp + RAMP_W'(1);
          end
        end
        S_CONV_DONE: begin
          if (!convert) begin
            w_nxt  = S_IDLE;
            w_ramp = '0;
          end
        end
        S_READ: begin
          if (!read) begin
            w_nxt  = S_IDLE;
            w_row  = '0;
            w_rsel = '0;
          end else if (r_row_cnt == ROW_LAST) begin
            w_row = '0;
            if (r_rsel[ROWS-1]) begin
              w_nxt  = S_READ_DONE;
              w_rsel = '0;
            end else begin
              w_rsel = r_rsel << 1;
            end
          end else begin
            w_row = r_row_cnt + RCW'(1);
          end
        end
        S_READ_DONE: if (!read) w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
      // ADC clear outranks the conversion phase's own transitions
      if (ADC_reset) begin
        w_ramp = '0;
        if (r_state == S_CONVERT || r_state == S_CONV_DONE)
          w_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge state_reset_n) begin
    if (!state_reset_n) begin
      r_state   <= S_IDLE;
      r_exp_cnt <= '0;
      r_ramp    <= '0;
      r_row_cnt <= '0;
      r_rsel    <= '0;
      r_expose  <= 1'b0;
      r_erase   <= 1'b0;
      r_exp_fin <= 1'b0;
      r_adc_fin <= 1'b0;
      r_rd_done <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_exp_cnt <= w_exp;
      r_ramp    <= w_ramp;
      r_row_cnt <= w_row;
      r_rsel    <= w_rsel;
      r_expose  <= (w_nxt == S_EXPOSE);
      r_erase   <= (w_nxt == S_ERASE);
      r_exp_fin <= (w_nxt == S_EXP_DONE);
      r_adc_fin <= (w_nxt == S_CONV_DONE);
      r_rd_done <= (w_nxt == S_READ_DONE);
    end
  end

  assign expose          = r_expose;
  assign erase           = r_erase;
  assign expose_finished = r_exp_fin;
  assign ADC_finished    = r_adc_fin;
  assign read_done       = r_rd_done;
  assign read_reg        = r_rsel;
  assign ramp_data       = r_ramp;

endmodule

// File: tb/tb_pixel_phase_responder.sv
// Directed bench for pixel_phase_responder with a 10-cycle exposure,
// 8-bit ramp and 4 rows of 2 cycles each.
module tb_pixel_phase_responder;

  logic       clk = 1'b0;
  logic       state_reset_n = 1'b0;
  logic       frame_reset = 1'b0;
  logic       expose_enable = 1'b0;
  logic       convert = 1'b0;
  logic       ADC_reset = 1'b0;
  logic       read = 1'b0;
  logic       expose_finished;
  logic       ADC_finished;
  logic [3:0] read_reg;
  logic       read_done;
  logic       erase;
  logic       expose;
  logic [7:0] ramp_data;

  int n_chk = 0;
  int n_pass = 0;

  pixel_phase_responder #(
    .EXPOSE_CYCLES(10),
    .RAMP_W(8),
    .ROWS(4),
    .ROW_CYCLES(2)
  ) dut (
    .clk(clk),
    .state_reset_n(state_reset_n),
    .frame_reset(frame_reset),
    .expose_enable(expose_enable),
    .convert(convert),
    .ADC_reset(ADC_reset),
    .read(read),
    .expose_finished(expose_finished),
    .ADC_finished(ADC_finished),
    .read_reg(read_reg),
    .read_done(read_done),
    .erase(erase),
    .expose(expose),
    .ramp_data(ramp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {expose_finished, ADC_finished, read_done, erase, expose,
            read_reg, ramp_data[6:0]} | {15'd0, ramp_data[7]};
  endfunction

  logic [3:0] rd_seq [8] = '{4'h1, 4'h1, 4'h2, 4'h2,
                             4'h4, 4'h4, 4'h8, 4'h8};

  initial begin
    #1;
    check("reset_outs", outs(), 16'd0);
    check("reset_ramp", ramp_data, 8'd0);
    step();
    state_reset_n = 1'b1;

    // exposure window
    expose_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("exp_on%0d", i), expose, 1'b1);
      check($sformatf("exp_fin0_%0d", i), expose_finished, 1'b0);
    end
    step();
    check("exp_off", expose, 1'b0);
    check("exp_fin", expose_finished, 1'b1);
    step();
    check("exp_fin_hold", expose_finished, 1'b1);
    expose_enable = 1'b0;
    step();
    check("exp_fin_rel", expose_finished, 1'b0);

    // exposure abort
    expose_enable = 1'b1;
    step(); step(); step();
    expose_enable = 1'b0;
    step();
    check("abort_exp", expose, 1'b0);
    check("abort_fin", expose_finished, 1'b0);
    step();

    // full conversion ramp
    convert = 1'b1;
    step();
    check("ramp_first", ramp_data, 8'd0);
    for (int i = 1; i < 255; i++) begin
      step();
      check($sformatf("ramp%0d", i), ramp_data, 32'(i));
      check($sformatf("adc_fin0_%0d", i), ADC_finished, 1'b0);
    end
    step();
    check("ramp_full", ramp_data, 8'd255);
    check("adc_fin", ADC_finished, 1'b1);
    step();
    check("ramp_hold", ramp_data, 8'd255);
    convert = 1'b0;
    step();
    check("ramp_clr", ramp_data, 8'd0);
    check("adc_fin_rel", ADC_finished, 1'b0);
    step();

    // ADC_reset at ramp 40
    convert = 1'b1;
    for (int i = 0; i < 41; i++) step();
    check("ramp40", ramp_data, 8'd40);
    ADC_reset = 1'b1;
    step();
    check("adcrst_ramp", ramp_data, 8'd0);
    check("adcrst_fin", ADC_finished, 1'b0);
    ADC_reset = 1'b0;
    convert = 1'b0;
    step();
    check("adcrst_idle", outs(), 16'd0);

    // readout
    read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("row%0d", i), read_reg, rd_seq[i]);
      check($sformatf("rd_done0_%0d", i), read_done, 1'b0);
    end
    step();
    check("rows_off", read_reg, 4'h0);
    check("rd_done", read_done, 1'b1);
    read = 1'b0;
    step();
    check("rd_done_rel", read_done, 1'b0);
    step();

    // simultaneous requests
    expose_enable = 1'b1;
    convert = 1'b1;
    read = 1'b1;
    step();
    check("sim_exp", expose, 1'b1);
    check("sim_rows", read_reg, 4'h0);
    for (int i = 0; i < 9; i++) step();
    step();
    check("sim_exp_fin", expose_finished, 1'b1);
    expose_enable = 1'b0;
    step();
    check("sim_idle", outs(), 16'd0);
    step();
    check("sim_conv0", ramp_data, 8'd0);
    step();
    check("sim_conv1", ramp_data, 8'd1);
    check("sim_conv_rows", read_reg, 4'h0);
    convert = 1'b0;
    step();
    check("sim_idle2", outs(), 16'd0);
    step();
    check("sim_read", read_reg, 4'h1);
    read = 1'b0;
    step();
    check("sim_read_abort", outs(), 16'd0);
    step();

    // frame_reset during conversion at ramp 17
    convert = 1'b1;
    for (int i = 0; i < 18; i++) step();
    check("ramp17", ramp_data, 8'd17);
    frame_reset = 1'b1;
    step();
    check("fr_erase", erase, 1'b1);
    check("fr_ramp", ramp_data, 8'd0);
    step();
    check("fr_erase_hold", erase, 1'b1);
    check("fr_flags", {expose_finished, ADC_finished, read_done}, 3'b0);
    frame_reset = 1'b0;
    convert = 1'b0;
    step();
    check("fr_release", outs(), 16'd0);
    step();

    // asynchronous reset mid-exposure
    expose_enable = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_exp", expose, 1'b1);
    state_reset_n = 1'b0;
    #1;
    check("async_rst", outs(), 16'd0);
    step();
    expose_enable = 1'b0;
    state_reset_n = 1'b1;
    step();
    check("post_rst", outs(), 16'd0);
    expose_enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("post_rst_cnt_exp", expose, 1'b1);
    check("post_rst_cnt_fin", expose_finished, 1'b0);
    step();
    check("post_rst_fin", expose_finished, 1'b1);
    expose_enable = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
